// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage register with a 2-entry skid buffer (main + skid).
// Optional perf counters (stall_cnt, bubble_cnt) are built when PIPE_STAGE_SKID_PERF_EN is defined.
module pipe_stage_skid #(
    parameter int                DATA_W = 64,
    parameter logic [DATA_W-1:0] BUBBLE = '0,
    parameter int                CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_data,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_SKID_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    // Handshake: a beat moves on an interface at a rising edge where valid and
    // ready are both high; dn_valid/dn_data stay frozen until dn_ready is seen.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t            state;
    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;
    // Inverse of the skid-occupied flag, held low through reset.
    logic              up_ready_q;

    logic in_xfer;
    logic out_xfer;

    assign in_xfer   = up_valid & up_ready_q;
    assign out_xfer  = main_valid & dn_ready;

    assign up_ready  = up_ready_q;
    assign dn_valid  = main_valid;
    assign dn_data   = main_data;
    assign occupancy = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_EMPTY;
            main_valid <= 1'b0;
            main_data  <= BUBBLE;
            skid_data  <= BUBBLE;
            up_ready_q <= 1'b0;
        end else if (flush) begin
            // Any same-cycle input beat is accepted and dropped here.
            state      <= S_EMPTY;
            main_valid <= 1'b0;
            main_data  <= BUBBLE;
            skid_data  <= BUBBLE;
            up_ready_q <= 1'b1;
        end else begin
            case (state)
                S_EMPTY: begin
                    up_ready_q <= 1'b1;
                    if (in_xfer) begin
                        main_data  <= up_data;
                        main_valid <= 1'b1;
                        state      <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_data <= up_data;
                    end else if (in_xfer) begin
                        skid_data  <= up_data;
                        up_ready_q <= 1'b0;
                        state      <= S_FULL;
                    end else if (out_xfer) begin
                        main_valid <= 1'b0;
                        main_data  <= BUBBLE;
                        state      <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    // up_ready is low here, so only the drain side can move.
                    if (out_xfer) begin
                        main_data  <= skid_data;
                        skid_data  <= BUBBLE;
                        up_ready_q <= 1'b1;
                        state      <= S_ONE;
                    end
                end
                default: begin
                    state      <= S_EMPTY;
                    main_valid <= 1'b0;
                    main_data  <= BUBBLE;
                    skid_data  <= BUBBLE;
                    up_ready_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_SKID_PERF_EN
    // Saturating counters; flush deliberately leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (main_valid && !dn_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (!main_valid && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
        end
    end
`else
    if (CNT_W < 1) begin : g_bad_cnt_w
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios with literal checks plus a
// randomized run compared every cycle against a queue-based reference model.
module tb_pipe_stage_skid;
  localparam int DW = 16;
  localparam logic [DW-1:0] BUB = 16'hDEAD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic up_valid = 1'b0;
  logic dn_ready = 1'b0;
  logic [DW-1:0] up_data = '0;
  logic up_ready;
  logic dn_valid;
  logic [DW-1:0] dn_data;
  logic [1:0] occupancy;
`ifdef PIPE_STAGE_SKID_PERF_EN
  logic [31:0] stall_cnt, bubble_cnt;
  logic up_ready4, dn_valid4;
  logic [DW-1:0] dn_data4;
  logic [1:0] occupancy4;
  logic [3:0] stall_cnt4, bubble_cnt4;
`endif

  int total = 0;
  int bad = 0;

  // clock / reset block
  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .BUBBLE(BUB), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
    .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_data(dn_data),
    .occupancy(occupancy)
`ifdef PIPE_STAGE_SKID_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

`ifdef PIPE_STAGE_SKID_PERF_EN
  pipe_stage_skid #(.DATA_W(DW), .BUBBLE(BUB), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush),
    .up_valid(up_valid), .up_ready(up_ready4), .up_data(up_data),
    .dn_valid(dn_valid4), .dn_ready(dn_ready), .dn_data(dn_data4),
    .occupancy(occupancy4), .stall_cnt(stall_cnt4), .bubble_cnt(bubble_cnt4)
  );
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // reference model: the stage is a FIFO of depth 2 with a registered ready
  logic [DW-1:0] exp_q[$];
  logic m_ready = 1'b0;
  logic m_known = 1'b0;
  longint m_stall = 0;
  longint m_bubble = 0;

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_ready = 1'b0;
      m_known = 1'b1;
      m_stall = 0;
      m_bubble = 0;
    end else if (m_known) begin
      logic in_x, out_x;
      if (exp_q.size() > 0 && !dn_ready) m_stall++;
      if (exp_q.size() == 0) m_bubble++;
      in_x = up_valid && m_ready;
      out_x = (exp_q.size() > 0) && dn_ready;
      if (out_x) void'(exp_q.pop_front());
      if (flush) exp_q.delete();
      else if (in_x) exp_q.push_back(up_data);
      m_ready = exp_q.size() < 2;
    end
  end

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    if (m_known) begin
      chk("up_ready", 64'(up_ready), 64'(m_ready));
      chk("dn_valid", 64'(dn_valid), 64'(exp_q.size() > 0));
      chk("dn_data", 64'(dn_data), 64'((exp_q.size() > 0) ? exp_q[0] : BUB));
      chk("occupancy", 64'(occupancy), 64'(exp_q.size()));
`ifdef PIPE_STAGE_SKID_PERF_EN
      chk("stall_cnt", 64'(stall_cnt), 64'(sat(m_stall, 32)));
      chk("bubble_cnt", 64'(bubble_cnt), 64'(sat(m_bubble, 32)));
      chk("stall_cnt4", 64'(stall_cnt4), 64'(sat(m_stall, 4)));
      chk("bubble_cnt4", 64'(bubble_cnt4), 64'(sat(m_bubble, 4)));
`endif
    end
  end

  // driver task: apply inputs, let one rising edge pass, settle
  task automatic step(input logic v, input logic [DW-1:0] d, input logic dr, input logic fl);
    up_valid = v;
    up_data = d;
    dn_ready = dr;
    flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input string tag, input logic ur, input logic dv,
                     input logic [DW-1:0] dd, input logic [1:0] oc);
    chk({tag, ".up_ready"}, 64'(up_ready), 64'(ur));
    chk({tag, ".dn_valid"}, 64'(dn_valid), 64'(dv));
    chk({tag, ".dn_data"}, 64'(dn_data), 64'(dd));
    chk({tag, ".occupancy"}, 64'(occupancy), 64'(oc));
  endtask

  initial begin
    // reset with upstream pushing
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 16'h5555, 1'b1, 1'b0);
      pin("reset", 1'b0, 1'b0, BUB, 2'd0);
    end
    rst = 1'b0;
    step(1'b0, 16'h0, 1'b1, 1'b0);
    pin("post_reset", 1'b1, 1'b0, BUB, 2'd0);

    // streaming at full rate
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, DW'(i), 1'b1, 1'b0);
      pin("stream", 1'b1, 1'b1, DW'(i), 2'd1);
    end
    step(1'b0, 16'h0, 1'b1, 1'b0);
    pin("stream_drain", 1'b1, 1'b0, BUB, 2'd0);

    // backpressure
    step(1'b1, 16'h00A0, 1'b0, 1'b0);
    pin("bp_a", 1'b1, 1'b1, 16'h00A0, 2'd1);
    step(1'b1, 16'h00B0, 1'b0, 1'b0);
    pin("bp_b", 1'b0, 1'b1, 16'h00A0, 2'd2);
    step(1'b1, 16'h00C0, 1'b0, 1'b0);
    pin("bp_c_wait", 1'b0, 1'b1, 16'h00A0, 2'd2);
    step(1'b1, 16'h00C0, 1'b1, 1'b0);
    pin("bp_out_a", 1'b1, 1'b1, 16'h00B0, 2'd1);
    step(1'b1, 16'h00C0, 1'b1, 1'b0);
    pin("bp_out_b", 1'b1, 1'b1, 16'h00C0, 2'd1);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    pin("bp_out_c", 1'b1, 1'b0, BUB, 2'd0);

    // flush while full with D offered
    step(1'b1, 16'h0A0A, 1'b0, 1'b0);
    step(1'b1, 16'h0B0B, 1'b0, 1'b0);
    pin("fl_full", 1'b0, 1'b1, 16'h0A0A, 2'd2);
    step(1'b1, 16'h0D0D, 1'b0, 1'b1);
    pin("flush", 1'b1, 1'b0, BUB, 2'd0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    pin("flush_no_d", 1'b1, 1'b0, BUB, 2'd0);
    // flush in ONE: in-beat consumed and dropped, out-beat completes
    step(1'b1, 16'h0E0E, 1'b0, 1'b0);
    step(1'b1, 16'h0F0F, 1'b1, 1'b1);
    pin("flush_one", 1'b1, 1'b0, BUB, 2'd0);
    step(1'b0, 16'h0, 1'b1, 1'b0);

`ifdef PIPE_STAGE_SKID_PERF_EN
    // perf: 3 bubble cycles, then 5 stall cycles, flush keeps counts
    rst = 1'b1;
    step(1'b0, 16'h0, 1'b0, 1'b0);
    rst = 1'b0;
    step(1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b1, 16'h1234, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("perf.stall5", 64'(stall_cnt), 64'd5);
    chk("perf.bubble3", 64'(bubble_cnt), 64'd3);
    step(1'b0, 16'h0, 1'b1, 1'b1);
    chk("perf.flush_stall", 64'(stall_cnt), 64'd5);
    chk("perf.flush_bubble", 64'(bubble_cnt), 64'd3);
    step(1'b1, 16'h4321, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("perf.stall25", 64'(stall_cnt), 64'd25);
    chk("perf.sat15", 64'(stall_cnt4), 64'd15);
    step(1'b0, 16'h0, 1'b1, 1'b0);
`endif

    // randomized run with phases of varying backpressure
    for (int c = 0; c < 10000; c++) begin
      int k;
      k = (c / 500) % 4;
      rst = ($urandom_range(0, 999) == 0);
      step($urandom_range(0, 3) != 0, DW'($urandom),
           $urandom_range(0, 3) < k, $urandom_range(0, 63) == 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
    pin("final_empty", 1'b1, 1'b0, BUB, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
